// File: rtl/seq_gen_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_serial_pkg
//  Description : Shared types and constants for the serial pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_gen_serial_pkg;

    // Transmission controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operation requested of the shift register each cycle
    typedef enum logic [1:0] {
        SH_HOLD  = 2'd0,
        SH_LOAD  = 2'd1,
        SH_SHIFT = 2'd2,
        SH_CLEAR = 2'd3
    } shift_op_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    // Width of a counter indexing n items; never below one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_shifter
//  Description : Parallel-load, MSB-first shift register with a bit counter
//                that wraps modulo PAT_W. The MSB is the serial output bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_shifter
    import seq_gen_serial_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk_out,
    input  logic             reset,
    input  shift_op_t        op,
    input  logic [PAT_W-1:0] load_data,
    output logic             msb,
    output logic             last_bit
);

    localparam int              BCW      = cnt_width(PAT_W);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(PAT_W - 1);

    logic [PAT_W-1:0] r_shreg;
    logic [BCW-1:0]   r_bit_cnt;

    // Shift register and bit position, updated by the controller's op code
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (op)
                SH_LOAD: begin
                    r_shreg   <= load_data;
                    r_bit_cnt <= '0;
                end
                SH_SHIFT: begin
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= (r_bit_cnt == LAST_IDX) ? '0 : r_bit_cnt + 1'b1;
                end
                SH_CLEAR: begin
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                end
                default: begin
                    r_shreg   <= r_shreg;
                    r_bit_cnt <= r_bit_cnt;
                end
            endcase
        end
    end

    assign msb      = r_shreg[PAT_W-1];
    assign last_bit = (r_bit_cnt == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/seq_gen_serial.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_serial
//  Description : Serial pattern generator. Sends a latched PAT_W-bit pattern
//                MSB first, repeat_n times back to back, then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_serial
    import seq_gen_serial_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

    state_t           r_state, w_state_next;
    logic [PAT_W-1:0] r_pat, w_pat_next;
    logic [CNT_W-1:0] r_rep, w_rep_next;
    logic             r_valid, w_valid_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    shift_op_t        w_op;
    logic [PAT_W-1:0] w_load_data;
    logic             w_msb;
    logic             w_last;

    seq_gen_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .clk_out   (clk_out),
        .reset     (reset),
        .op        (w_op),
        .load_data (w_load_data),
        .msb       (w_msb),
        .last_bit  (w_last)
    );

    // State, latched request and registered status flags
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_rep   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pat   <= w_pat_next;
            r_rep   <= w_rep_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next state, shifter control and next-cycle output values
    always_comb begin
        w_state_next = r_state;
        w_pat_next   = r_pat;
        w_rep_next   = r_rep;
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_op         = SH_HOLD;
        w_load_data  = r_pat;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_pat_next  = pattern;
                    w_rep_next  = repeat_n;
                    w_busy_next = 1'b1;
                    if (repeat_n != '0) begin
                        w_state_next = SHIFT;
                        w_op         = SH_LOAD;
                        w_load_data  = pattern;
                        w_valid_next = 1'b1;
                    end else begin
                        // Nothing to send: go straight to the done pulse
                        w_state_next = DONE;
                        w_op         = SH_CLEAR;
                        w_done_next  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_busy_next = 1'b1;
                if (!w_last) begin
                    w_op         = SH_SHIFT;
                    w_valid_next = 1'b1;
                end else if (r_rep > REP_ONE) begin
                    // Next repetition follows with no gap cycle
                    w_op         = SH_LOAD;
                    w_rep_next   = r_rep - 1'b1;
                    w_valid_next = 1'b1;
                end else begin
                    // Clearing the shifter drives x to 0 alongside x_valid=0
                    w_op         = SH_CLEAR;
                    w_rep_next   = '0;
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
                w_op         = SH_CLEAR;
            end
            default: begin
                w_state_next = IDLE;
                w_op         = SH_CLEAR;
            end
        endcase
    end

    assign x       = w_msb;
    assign x_valid = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen_serial
//  Description : Directed self-checking bench for seq_gen_serial.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen_serial;

    logic       clk_out = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_n;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    seq_gen_serial #(
        .PAT_W (4),
        .CNT_W (4)
    ) dut (
        .clk_out  (clk_out),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_out = ~clk_out;

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    // Runs one transmission already requested (start high before the next
    // edge), recording serial bits and status until busy falls.
    task automatic collect(input int max_cyc, input int poke_at, input logic [3:0] poke_pat,
                           output logic [63:0] bits, output int nvalid, output int ndone,
                           output int nbusy, output int done_cyc,
                           output bit gap, output bit xbad, output bit timeout);
        bit seen, prev_valid, finished;
        bits = '0; nvalid = 0; ndone = 0; nbusy = 0; done_cyc = -1;
        gap = 0; xbad = 0; timeout = 0;
        seen = 0; prev_valid = 0; finished = 0;
        for (int cyc = 1; cyc <= max_cyc && !finished; cyc++) begin
            tick();
            if (x_valid === 1'b1) begin
                bits = {bits[62:0], x};
                nvalid++;
                if (seen && !prev_valid) gap = 1;
                seen = 1;
            end else if (x !== 1'b0) begin
                xbad = 1;
            end
            prev_valid = (x_valid === 1'b1);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin ndone++; done_cyc = cyc; end
            if (busy !== 1'b1) finished = 1;
            if (cyc == 1) start = 1'b0;
            if (cyc == poke_at) begin
                start = 1'b1; pattern = poke_pat; repeat_n = 4'd5;
            end else if (poke_at > 0 && cyc == poke_at + 1) begin
                start = 1'b0;
            end
        end
        if (!finished) timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (x !== 1'b0)       begin n_bad++; $display("FAIL reset_x: got %b want 0", x); end
        n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        pattern = 4'b1010; repeat_n = 4'd1; start = 1'b1;
        collect(20, 0, 4'b0, b, nv, nd, nb, dc, g, xb, to);
        n_cmp++; if (to)            begin n_bad++; $display("FAIL single_timeout: got 1 want 0"); end
        n_cmp++; if (b[3:0] !== 4'b1010) begin n_bad++; $display("FAIL single_bits: got %b want 1010", b[3:0]); end
        n_cmp++; if (nv != 4)       begin n_bad++; $display("FAIL single_nvalid: got %0d want 4", nv); end
        n_cmp++; if (g)             begin n_bad++; $display("FAIL single_gap: got 1 want 0"); end
        n_cmp++; if (dc != 5)       begin n_bad++; $display("FAIL single_done_cycle: got %0d want 5", dc); end
        n_cmp++; if (nd != 1)       begin n_bad++; $display("FAIL single_ndone: got %0d want 1", nd); end
        n_cmp++; if (nb != 5)       begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 5", nb); end
        n_cmp++; if (xb)            begin n_bad++; $display("FAIL single_x_idle_zero: got 1 want 0"); end
    endtask

    task automatic test_repeat();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        pattern = 4'b1010; repeat_n = 4'd3; start = 1'b1;
        collect(30, 0, 4'b0, b, nv, nd, nb, dc, g, xb, to);
        n_cmp++; if (to)            begin n_bad++; $display("FAIL repeat_timeout: got 1 want 0"); end
        n_cmp++; if (b[11:0] !== 12'b101010101010) begin n_bad++; $display("FAIL repeat_bits: got %b want 101010101010", b[11:0]); end
        n_cmp++; if (nv != 12)      begin n_bad++; $display("FAIL repeat_nvalid: got %0d want 12", nv); end
        n_cmp++; if (g)             begin n_bad++; $display("FAIL repeat_gap: got 1 want 0"); end
        n_cmp++; if (nd != 1)       begin n_bad++; $display("FAIL repeat_ndone: got %0d want 1", nd); end
        n_cmp++; if (dc != 13)      begin n_bad++; $display("FAIL repeat_done_cycle: got %0d want 13", dc); end
    endtask

    task automatic test_zero_repeat();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        pattern = 4'b1111; repeat_n = 4'd0; start = 1'b1;
        collect(10, 0, 4'b0, b, nv, nd, nb, dc, g, xb, to);
        n_cmp++; if (to)            begin n_bad++; $display("FAIL zero_timeout: got 1 want 0"); end
        n_cmp++; if (nv != 0)       begin n_bad++; $display("FAIL zero_nvalid: got %0d want 0", nv); end
        n_cmp++; if (dc != 1)       begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
        n_cmp++; if (nb != 1)       begin n_bad++; $display("FAIL zero_busy_cycles: got %0d want 1", nb); end
        n_cmp++; if (xb)            begin n_bad++; $display("FAIL zero_x_idle_zero: got 1 want 0"); end
    endtask

    task automatic test_ignore_start();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        pattern = 4'b1100; repeat_n = 4'd2; start = 1'b1;
        collect(30, 3, 4'b0011, b, nv, nd, nb, dc, g, xb, to);
        start = 1'b0;
        n_cmp++; if (to)            begin n_bad++; $display("FAIL ignore_timeout: got 1 want 0"); end
        n_cmp++; if (b[7:0] !== 8'b11001100) begin n_bad++; $display("FAIL ignore_bits: got %b want 11001100", b[7:0]); end
        n_cmp++; if (nv != 8)       begin n_bad++; $display("FAIL ignore_nvalid: got %0d want 8", nv); end
        n_cmp++; if (nd != 1)       begin n_bad++; $display("FAIL ignore_ndone: got %0d want 1", nd); end
    endtask

    task automatic test_reset_abort();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        logic [2:0] first;
        bit done_seen;
        pattern = 4'b1010; repeat_n = 4'd2; start = 1'b1;
        first = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            first = {first[1:0], x};
        end
        n_cmp++; if (first !== 3'b101) begin n_bad++; $display("FAIL abort_first_bits: got %b want 101", first); end
        // Assert reset between clock edges; outputs must clear without a clock
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({x, x_valid, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL abort_async_clear: got %b want 0000", {x, x_valid, busy, done});
        end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0) done_seen = 1;
        end
        reset = 1'b0;
        tick();
        if (done !== 1'b0) done_seen = 1;
        n_cmp++; if (done_seen)     begin n_bad++; $display("FAIL abort_no_done: got 1 want 0"); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_after: got %b want 0", busy); end
        pattern = 4'b1010; repeat_n = 4'd2; start = 1'b1;
        collect(30, 0, 4'b0, b, nv, nd, nb, dc, g, xb, to);
        n_cmp++; if (to)            begin n_bad++; $display("FAIL abort_restart_timeout: got 1 want 0"); end
        n_cmp++; if (b[7:0] !== 8'b10101010) begin n_bad++; $display("FAIL abort_restart_bits: got %b want 10101010", b[7:0]); end
        n_cmp++; if (nv != 8)       begin n_bad++; $display("FAIL abort_restart_nvalid: got %0d want 8", nv); end
        n_cmp++; if (nd != 1)       begin n_bad++; $display("FAIL abort_restart_ndone: got %0d want 1", nd); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bv, vv, dv;
        bit drained;
        bv = '0; vv = '0; dv = '0;
        pattern = 4'b1010; repeat_n = 4'd1; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            bv = {bv[10:0], busy};
            vv = {vv[10:0], x_valid};
            dv = {dv[10:0], done};
        end
        start = 1'b0;
        n_cmp++; if (bv !== 12'b111110111110) begin n_bad++; $display("FAIL b2b_busy: got %b want 111110111110", bv); end
        n_cmp++; if (vv !== 12'b111100111100) begin n_bad++; $display("FAIL b2b_valid: got %b want 111100111100", vv); end
        n_cmp++; if (dv !== 12'b000010000010) begin n_bad++; $display("FAIL b2b_done: got %b want 000010000010", dv); end
        drained = 0;
        for (int i = 0; i < 10 && !drained; i++) begin
            tick();
            if (busy === 1'b0) drained = 1;
        end
        n_cmp++; if (!drained) begin n_bad++; $display("FAIL b2b_drain: got busy want idle"); end
    endtask

    task automatic test_max_repeat();
        logic [63:0] b; int nv, nd, nb, dc; bit g, xb, to;
        logic [59:0] want;
        want = {15{4'b1001}};
        pattern = 4'b1001; repeat_n = 4'd15; start = 1'b1;
        collect(90, 0, 4'b0, b, nv, nd, nb, dc, g, xb, to);
        n_cmp++; if (to)            begin n_bad++; $display("FAIL max_timeout: got 1 want 0"); end
        n_cmp++; if (b[59:0] !== want) begin n_bad++; $display("FAIL max_bits: got %h want %h", b[59:0], want); end
        n_cmp++; if (nv != 60)      begin n_bad++; $display("FAIL max_nvalid: got %0d want 60", nv); end
        n_cmp++; if (g)             begin n_bad++; $display("FAIL max_gap: got 1 want 0"); end
        n_cmp++; if (nb != 61)      begin n_bad++; $display("FAIL max_busy_cycles: got %0d want 61", nb); end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = 4'b0;
        repeat_n = 4'b0;
        test_reset();
        test_single();
        test_repeat();
        test_zero_repeat();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_max_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/seq_gen_serial.md
SEQ_GEN_SERIAL -- requirements
Module: seq_gen_serial

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set the pattern width in bits.
REQ-002 Parameter CNT_W, default 4, SHALL set the repeat-count width in bits.
REQ-003 clk_out  input  1  SHALL be the clock; all state advances on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: reset, asynchronous, active-high; clock clk_out.
REQ-005 start  input  1  SHALL request a transmission; it is sampled only in IDLE.
REQ-006 pattern  input  PAT_W  SHALL be the pattern to send, MSB first, captured when start is accepted.
REQ-007 repeat_n  input  CNT_W  SHALL be the number of back-to-back pattern repetitions, captured when start is accepted.
REQ-008 x  output  1  SHALL be the registered serial data bit.
REQ-009 x_valid  output  1  SHALL be high exactly in the cycles where x carries a pattern bit.
REQ-010 busy  output  1  SHALL be high in any state other than IDLE.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking the end of a transmission.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE; all outputs SHALL be registered.
REQ-013 IDLE with start=1 at edge k, and repeat_n>0: pattern and repeat_n are latched, and the FSM enters SHIFT with x=pattern[PAT_W-1] and x_valid=1 from edge k.
REQ-014 IDLE with start=1 and repeat_n=0: the FSM enters DONE at edge k with x_valid=0, so done is high in the cycle after k and no bits are sent.
REQ-015 In SHIFT, each edge SHALL advance x to the next lower pattern bit and increment a bit counter modulo PAT_W.
REQ-016 After bit 0 of a repetition, if repetitions remain, the next edge SHALL reload the latched pattern with no gap cycle (x_valid stays 1).
REQ-017 After bit 0 of the last repetition, the next edge SHALL enter DONE with x_valid=0 and x=0.
REQ-018 DONE SHALL last exactly one cycle (done=1, busy=1) and then return to IDLE.
REQ-019 A transmission SHALL produce exactly PAT_W*repeat_n valid bits.
REQ-020 start while busy=1 SHALL be ignored, and neither latched value SHALL change mid-transmission.
REQ-021 start held high through DONE SHALL be accepted in the following IDLE cycle, giving exactly one idle cycle between transmissions.
REQ-022 When x_valid=0, x SHALL be driven 0.
REQ-023 The repeat counter SHALL count down from the latched repeat_n; the all-ones value SHALL be legal, with no wrap.

Reset
REQ-024 While reset=1, state SHALL be IDLE and x, x_valid, busy and done SHALL be 0, independent of clk_out.
REQ-025 Reset asserted mid-SHIFT SHALL abort immediately, with no done pulse; after deassertion, the next accepted start begins a fresh transmission.
REQ-026 Latched pattern and counters SHALL reset to 0.

Structure
REQ-027 A shared package SHALL hold the state typedef (IDLE/SHIFT/DONE) and the constant DEFAULT_PATTERN = 4'b1010.
REQ-028 One sub-module, seq_gen_shifter, SHALL hold the parallel-load MSB-first shift register and the bit counter; the FSM and repeat counter stay in seq_gen_serial.

Verification
REQ-029 pattern=1010, repeat_n=1, start pulse -> x=1,0,1,0 with x_valid on 4 consecutive cycles; done in cycle 5; busy for 5 cycles.
REQ-030 pattern=1010, repeat_n=3 -> 12 contiguous valid bits 101010101010, then one done pulse.
REQ-031 repeat_n=0 -> no x_valid; done one cycle after start; busy for 1 cycle.
REQ-032 pattern=1100, repeat_n=2; start re-pulsed and pattern changed to 0011 mid-transmission -> output stays 11001100, with a single done pulse.
REQ-033 pattern=1010, repeat_n=2; reset asserted after 3 bits -> all outputs 0 at once, no done pulse; a new start afterwards -> the full 8-bit sequence.
REQ-034 start held high continuously, repeat_n=1 -> transmissions separated by exactly one idle cycle after each done.
